key_led_ctrl: RTL and testbench

Parametrised multi-channel key-to-LED controller: the next generation of our single-bit key/LED flip-flop. Each of `CH_NUM` key inputs is synchronised, debounced and turned into a one-cycle press flag. Each channel drives an LED in one of three runtime-selectable modes: follow, toggle or pulse-stretch. The block sits between the board push-buttons and the LED pins.

---
 rtl/key_led_ctrl.sv | 139 +++++++++++++
 tb/tb_key_led_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/key_led_ctrl.sv
// ----------------------------------------------------------------------------
// key_led_ctrl
//
// Multi-channel key-to-LED controller. Each raw key input is passed through a
// 2-FF synchroniser, debounced by a per-channel stability counter and turned
// into a one-cycle press flag. Each LED is driven in one of three modes shared
// by all channels: follow the debounced key, toggle on each press, or light
// for a fixed stretch time after the most recent press.
//
// Ports:
//   sys_clk    in   1       system clock, rising edge
//   sys_rst_n  in   1       asynchronous active-low reset
//   key_in     in   CH_NUM  raw asynchronous key levels
//   mode       in   2       00 follow, 01 toggle, 10 pulse, 11 follow
//   key_flag   out  CH_NUM  one-cycle pulse per accepted press
//   led_out    out  CH_NUM  LED drive, 1 = on
// ----------------------------------------------------------------------------
module key_led_ctrl #(
    parameter int unsigned CH_NUM       = 4,
    parameter int unsigned DEBOUNCE_CNT = 20,
    parameter int unsigned STRETCH_CNT  = 16,
    parameter logic        KEY_ACTIVE   = 1'b0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [CH_NUM-1:0] key_in,
    input  logic [1:0]        mode,
    output logic [CH_NUM-1:0] key_flag,
    output logic [CH_NUM-1:0] led_out
);

    // Widths sized to hold the terminal value (count - 1), never below 1 bit.
    localparam int unsigned DB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam int unsigned ST_W = (STRETCH_CNT > 1) ? $clog2(STRETCH_CNT) : 1;

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [ST_W-1:0]   ST_LOAD  = ST_W'(STRETCH_CNT - 1);
    // Released level; synchroniser and debounced state start here so that
    // leaving reset never looks like a press.
    localparam logic [CH_NUM-1:0] IDLE_LVL = {CH_NUM{~KEY_ACTIVE}};

    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_PULSE  = 2'b10;

    logic [CH_NUM-1:0] s1;
    logic [CH_NUM-1:0] s2;
    logic [CH_NUM-1:0] key_stable;
    logic [DB_W-1:0]   db_cnt [CH_NUM];
    logic [ST_W-1:0]   st_cnt [CH_NUM];
    logic [1:0]        mode_q;

    logic [CH_NUM-1:0] stable_d;
    logic [CH_NUM-1:0] flag_d;
    logic [DB_W-1:0]   db_cnt_d [CH_NUM];
    logic [CH_NUM-1:0] led_d;
    logic [ST_W-1:0]   st_cnt_d [CH_NUM];
    logic              mode_chg;

    // Debounce: a differing level must persist DEBOUNCE_CNT consecutive cycles;
    // any return to the accepted level restarts the count.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            stable_d[i] = key_stable[i];
            flag_d[i]   = 1'b0;
            db_cnt_d[i] = '0;
            if (s2[i] != key_stable[i]) begin
                if (db_cnt[i] == DB_LAST) begin
                    stable_d[i] = s2[i];
                    flag_d[i]   = (s2[i] == KEY_ACTIVE);
                end else begin
                    db_cnt_d[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // LED modes. A mode change clears every LED and stretch counter on that
    // edge and overrides any flag arriving at the same time.
    always_comb begin
        mode_chg = (mode != mode_q);
        for (int i = 0; i < CH_NUM; i++) begin
            led_d[i]    = led_out[i];
            st_cnt_d[i] = st_cnt[i];
            if (mode_chg) begin
                led_d[i]    = 1'b0;
                st_cnt_d[i] = '0;
            end else begin
                case (mode_q)
                    MODE_TOGGLE: begin
                        if (key_flag[i]) begin
                            led_d[i] = ~led_out[i];
                        end
                    end
                    MODE_PULSE: begin
                        if (key_flag[i]) begin
                            led_d[i]    = 1'b1;
                            st_cnt_d[i] = ST_LOAD;
                        end else if (st_cnt[i] != '0) begin
                            led_d[i]    = 1'b1;
                            st_cnt_d[i] = st_cnt[i] - 1'b1;
                        end else begin
                            led_d[i]    = 1'b0;
                        end
                    end
                    default: begin
                        led_d[i] = (key_stable[i] == KEY_ACTIVE);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1         <= IDLE_LVL;
            s2         <= IDLE_LVL;
            key_stable <= IDLE_LVL;
            key_flag   <= '0;
            led_out    <= '0;
            mode_q     <= 2'b00;
            for (int i = 0; i < CH_NUM; i++) begin
                db_cnt[i] <= '0;
                st_cnt[i] <= '0;
            end
        end else begin
            s1         <= key_in;
            s2         <= s1;
            key_stable <= stable_d;
            key_flag   <= flag_d;
            led_out    <= led_d;
            mode_q     <= mode;
            for (int i = 0; i < CH_NUM; i++) begin
                db_cnt[i] <= db_cnt_d[i];
                st_cnt[i] <= st_cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_key_led_ctrl.sv
// ----------------------------------------------------------------------------
// tb_key_led_ctrl
//
// Directed bench for key_led_ctrl with CH_NUM=4, DEBOUNCE_CNT=5, STRETCH_CNT=8,
// active-low keys and a 10 ns clock. A second instance with STRETCH_CNT=16
// shares all inputs so that a pulse retrigger lands while the LED is still on.
// Inputs change and outputs are sampled 1 ns after each rising edge; "edge k"
// is the k-th rising edge after a new key level is driven.
// ----------------------------------------------------------------------------
module tb_key_led_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic [1:0] mode;
    logic [3:0] key_flag;
    logic [3:0] led_out;
    logic [3:0] key_flag_long;
    logic [3:0] led_out_long;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_led_ctrl #(
        .CH_NUM      (4),
        .DEBOUNCE_CNT(5),
        .STRETCH_CNT (8),
        .KEY_ACTIVE  (1'b0)
    ) u_dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .key_in   (key_in),
        .mode     (mode),
        .key_flag (key_flag),
        .led_out  (led_out)
    );

    key_led_ctrl #(
        .CH_NUM      (4),
        .DEBOUNCE_CNT(5),
        .STRETCH_CNT (16),
        .KEY_ACTIVE  (1'b0)
    ) u_dut_long (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .key_in   (key_in),
        .mode     (mode),
        .key_flag (key_flag_long),
        .led_out  (led_out_long)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b1;
        key_in = 4'hF;
        mode   = 2'b00;

        // Reset and idle
        #2 rst_n = 1'b0;
        #1;
        check("rst_led", led_out, 4'h0);
        check("rst_flag", key_flag, 4'h0);
        #19 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("idle_led", led_out, 4'h0);
            check("idle_flag", key_flag, 4'h0);
        end

        // Clean press and release on ch0, follow mode
        key_in[0] = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            step();
            check("follow_flag0", key_flag[0], k == 6);
            check("follow_led0", led_out[0], k >= 7);
        end
        check("follow_flag_oth", key_flag[3:1], 3'b000);
        key_in[0] = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            step();
            check("release_flag0", key_flag[0], 1'b0);
            check("release_led0", led_out[0], k < 7);
        end

        // Bounce on ch1: 4 low samples, 1 high, then low
        for (int k = 0; k <= 14; k++) begin
            key_in[1] = (k == 4);
            step();
            check("bounce_flag1", key_flag[1], k == 11);
            check("bounce_led1", led_out[1], k >= 12);
        end
        key_in[1] = 1'b1;
        repeat (10) step();
        check("bounce_rel_led", led_out, 4'h0);

        // Toggle mode, three presses on ch2
        mode = 2'b01;
        step();
        check("toggle_mode_clr", led_out, 4'h0);
        for (int p = 0; p < 3; p++) begin
            key_in[2] = 1'b0;
            for (int k = 0; k <= 7; k++) begin
                step();
                check("toggle_flag2", key_flag[2], k == 6);
                if (k == 6) check("toggle_led2_hold", led_out[2], (p % 2) == 1);
                if (k == 7) check("toggle_led2_new", led_out[2], (p % 2) == 0);
            end
            key_in[2] = 1'b1;
            repeat (10) step();
            check("toggle_led2_rel", led_out[2], (p % 2) == 0);
        end

        // Pulse mode on ch3: flags at edges 6 and 16
        mode = 2'b10;
        step();
        check("pulse_mode_clr", led_out, 4'h0);
        step();
        for (int k = 0; k <= 34; k++) begin
            key_in[3] = (k >= 5 && k < 10);
            step();
            check("pulse_flag3", key_flag[3], (k == 6) || (k == 16));
            check("pulse_led3", led_out[3], (k >= 7 && k <= 14) || (k >= 17 && k <= 24));
            check("retrig_led3", led_out_long[3], (k >= 7 && k <= 32));
        end

        // Reset in the middle of a pulse, keys ch0 and ch3 held
        key_in[0] = 1'b0;
        repeat (8) step();
        check("pre_rst_led0", led_out[0], 1'b1);
        rst_n = 1'b0;
        #2;
        check("async_rst_led", led_out, 4'h0);
        check("async_rst_led_long", led_out_long, 4'h0);
        check("async_rst_flag", key_flag, 4'h0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            step();
            check("post_rst_flag0", key_flag[0], k == 6);
            check("post_rst_flag3", key_flag[3], k == 6);
        end
        check("post_rst_led", led_out, 4'b1001);

        // Mode change 01 -> 00 while a toggled LED is on
        key_in = 4'hF;
        repeat (20) step();
        check("pulse_expired", led_out, 4'h0);
        mode = 2'b01;
        step();
        step();
        key_in[2] = 1'b0;
        repeat (8) step();
        check("mc_led2_on", led_out[2], 1'b1);
        key_in[2] = 1'b1;
        repeat (10) step();
        check("mc_led2_held", led_out[2], 1'b1);
        mode = 2'b00;
        step();
        check("mc_clear", led_out, 4'h0);
        step();
        check("mc_follow_idle", led_out, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
